collision_detect: RTL and testbench
===================================

Name: collision_detect

Overview:
- Downstream consumer of the per-pixel object values produced by the video peripheral: player 0/1, missile 0/1, ball, playfield.
- Latches the 15 pairwise object overlaps (TIA-style collision latches) and captures the screen position of the first unmasked hit each frame.
- Exposes the latches on an 8-bit register port decoded inside the peripheral block's address space.

Parameters:
- POS_WIDTH, 10, width of hpos/vpos inputs and captured position.

Ports:
- clk  input  1  system clock (raw_clk domain); all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pixel_strobe  input  1  one-cycle qualifier, high once per displayed pixel.
- in_image  input  1  high while beam is inside the active image.
- frame_start  input  1  one-cycle pulse at start of each frame.
- hpos  input  POS_WIDTH  current beam x.
- vpos  input  POS_WIDTH  current beam y.
- obj_values  input  6  {playfield, ball, missile_1, missile_0, player_1, player_0}, bit 0 = player_0.
- address  input  4  register select.
- data_in  input  8  write data.
- write_enable  input  1  register write strobe.
- enable  input  1  register read strobe.
- data_out  output  8  registered read data.
- irq  output  1  collision interrupt (only with COLLISION_IRQ_EN; tied 0 otherwise).

Behaviour:
- Reset: all outputs are async-reset to 0, and so are all registers: cx[14:0], mask[14:0], first_valid, first_h, first_v, irq_pending, data_out. Release takes effect on the next clk edge.
- Pair index (bit n of cx):
  - 0 P0-P1, 1 P0-M0, 2 P0-M1, 3 P0-BL, 4 P0-PF
  - 5 P1-M0, 6 P1-M1, 7 P1-BL, 8 P1-PF
  - 9 M0-M1, 10 M0-BL, 11 M0-PF
  - 12 M1-BL, 13 M1-PF
  - 14 BL-PF
- Sample: hit[n] = AND of the pair's two obj_values bits, qualified by pixel_strobe && in_image.
- Latch update: cx bit sets at the clk edge of the qualifying cycle; it is visible on a read issued the following cycle. Bits are sticky until cleared.
- Masking: mask affects only first-hit capture and irq. cx always records every hit.
- First-hit capture:
  - On the first qualifying cycle with (hit & ~mask) != 0 while first_valid==0: first_h<=hpos, first_v<=vpos, first_valid<=1.
  - Subsequent hits do not overwrite.
- State machine: ARMED (first_valid=0) -> CAPTURED on first unmasked hit. CAPTURED -> ARMED on frame_start or a write to 0x8 with bit0=1.
- frame_start does not clear cx.
- Register map (reads: data_out updated one cycle after enable; writes when write_enable):
  - 0x0 R cx[7:0]; W any value clears all cx.
  - 0x1 R {0,cx[14:8]}; W any value clears all cx.
  - 0x2 RW mask[7:0].
  - 0x3 RW mask[14:8], data_in[6:0].
  - 0x4 R first_h[7:0].
  - 0x5 R first_h[9:8] in bits [1:0].
  - 0x6 R first_v[7:0].
  - 0x7 R first_v[9:8] in bits [1:0].
  - 0x8 R {6'b0, irq_pending, first_valid}; W bit0=1 re-arms capture, bit1=1 clears irq_pending.
  - 0x9-0xF R 0; W ignored.
- write_enable and enable both high: write performed, data_out holds previous value.
- Simultaneous events:
  - cx clear and new hit in the same cycle: the hit wins; that pair's bit ends at 1, others 0.
  - frame_start coincident with an unmasked hit: the capture happens (re-arm then capture in the same cycle); position = that pixel.
  - Re-arm write coincident with an unmasked hit: same rule, the hit is captured.
- Hits outside in_image or without pixel_strobe are ignored entirely.
- Mid-operation reset clears all state immediately, regardless of clk.

Optional Feature:
- Macro: COLLISION_IRQ_EN.
- Defined:
  - irq_pending sets when the first-hit capture fires.
  - irq = irq_pending, registered.
  - Clear only via a write to 0x8 with bit1=1. If the clear and a new capture coincide, set wins.
- Undefined: irq_pending logic omitted; irq is constant 0; reg 0x8 bit1 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read 0x0..0x8 -> all read 0x00; irq=0.
- obj_values=6'b000011, pixel_strobe=1, in_image=1, hpos=100, vpos=37, one cycle -> reg0x0=0x01; 0x4=0x64, 0x5=0x00, 0x6=0x25; 0x8=0x01 (0x03 with IRQ_EN, irq=1).
- Same stimulus with in_image=0 or pixel_strobe=0 -> cx=0, first_valid=0.
- mask[14]=1 (write 0x3=0x40), obj_values=6'b110000 at hpos=600 -> 0x1=0x40, 0x8=0x00.
  - Then obj_values=6'b000101 at hpos=601 -> 0x0=0x02, first_h=601 (0x5=0x02, 0x4=0x59).
- With cx=0x7FFF, write 0x0 in the same cycle as an M0-M1 hit (obj_values=6'b001100) -> 0x0=0x00, 0x1=0x02.
- After capture, pulse frame_start, then a hit at hpos=5, vpos=500 -> first_h=5, first_v=500 (0x7=0x01, 0x6=0xF4).
- Assert reset mid-frame with cx nonzero -> all cleared asynchronously.

Source files
------------

// File: rtl/collision_detect.sv
// ---------------------------------------------------------------------------
// collision_detect
//
// Purpose:
//   Watches the per-pixel object values from the video peripheral (player
//   0/1, missile 0/1, ball, playfield). It latches each of the 15 pairwise
//   overlaps into sticky collision bits. It also records the beam position
//   of the first unmasked overlap after each re-arm. The state is read and
//   written through a small 8-bit register window.
//
// Build option:
//   COLLISION_IRQ_EN - when defined, a pending-interrupt flag sets on every
//                      first-hit capture and drives irq. When undefined, irq
//                      is tied 0 and register 0x8 bit1 reads 0.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   pixel_strobe one-cycle qualifier, high once per displayed pixel
//   in_image     high while the beam is inside the active image
//   frame_start  one-cycle pulse at the start of each frame
//   hpos, vpos   current beam position (POS_WIDTH bits)
//   obj_values   {PF, BL, M1, M0, P1, P0}, bit 0 = player 0
//   address      register select (0x0..0xF)
//   data_in      register write data
//   write_enable register write strobe
//   enable       register read strobe
//   data_out     registered read data, updated one cycle after enable
//   irq          collision interrupt (0 unless COLLISION_IRQ_EN)
// ---------------------------------------------------------------------------
module collision_detect #(
  parameter int POS_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pixel_strobe,
  input  logic                 in_image,
  input  logic                 frame_start,
  input  logic [POS_WIDTH-1:0] hpos,
  input  logic [POS_WIDTH-1:0] vpos,
  input  logic [5:0]           obj_values,
  input  logic [3:0]           address,
  input  logic [7:0]           data_in,
  input  logic                 write_enable,
  input  logic                 enable,
  output logic [7:0]           data_out,
  output logic                 irq
);

  // The capture engine is either waiting for a first unmasked hit (ARMED)
  // or holding a position it already captured (CAPTURED).
  typedef enum logic {
    ARMED    = 1'b0,
    CAPTURED = 1'b1
  } capState_e;

  capState_e state_q, state_d;

  logic                 pixelQual;
  logic [14:0]          hit;
  logic [14:0]          unmaskedHit;
  logic                 anyUnmasked;

  logic                 wrCx;
  logic                 wrMaskLo;
  logic                 wrMaskHi;
  logic                 wrCtrl;
  logic                 rearm;
  logic                 captureFire;
  logic                 firstValid;
  logic                 irqPending;

  logic [14:0]          cx_q, cx_d;
  logic [14:0]          mask_q, mask_d;
  logic [POS_WIDTH-1:0] firstH_q, firstH_d;
  logic [POS_WIDTH-1:0] firstV_q, firstV_d;
  logic [7:0]           dataOut_q, dataOut_d;
  logic [7:0]           readData;

  // Only a displayed pixel inside the active image counts. Each pair bit is
  // the AND of the two objects it names. The bit order runs P0 against
  // everything, then P1 against the rest, and so on down to BL-PF.
  assign pixelQual = pixel_strobe & in_image;

  always_comb begin
    hit = '0;
    if (pixelQual) begin
      hit[0]  = obj_values[0] & obj_values[1];
      hit[1]  = obj_values[0] & obj_values[2];
      hit[2]  = obj_values[0] & obj_values[3];
      hit[3]  = obj_values[0] & obj_values[4];
      hit[4]  = obj_values[0] & obj_values[5];
      hit[5]  = obj_values[1] & obj_values[2];
      hit[6]  = obj_values[1] & obj_values[3];
      hit[7]  = obj_values[1] & obj_values[4];
      hit[8]  = obj_values[1] & obj_values[5];
      hit[9]  = obj_values[2] & obj_values[3];
      hit[10] = obj_values[2] & obj_values[4];
      hit[11] = obj_values[2] & obj_values[5];
      hit[12] = obj_values[3] & obj_values[4];
      hit[13] = obj_values[3] & obj_values[5];
      hit[14] = obj_values[4] & obj_values[5];
    end
  end

  // The mask only gates first-hit capture and the interrupt. The sticky
  // latches always see every hit.
  assign unmaskedHit = hit & ~mask_q;
  assign anyUnmasked = |unmaskedHit;

  // Register write decodes
  assign wrCx     = write_enable && ((address == 4'h0) || (address == 4'h1));
  assign wrMaskLo = write_enable && (address == 4'h2);
  assign wrMaskHi = write_enable && (address == 4'h3);
  assign wrCtrl   = write_enable && (address == 4'h8);

  // A re-arm in the same cycle as an unmasked hit still captures that hit.
  // The re-arm is treated as taking effect first, then the capture fires.
  assign rearm       = frame_start || (wrCtrl && data_in[0]);
  assign captureFire = ((state_q == ARMED) || rearm) && anyUnmasked;

  // Capture FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture FSM: next-state logic. A capture has priority over a re-arm,
  // so a coincident re-arm and hit lands in CAPTURED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (captureFire) begin
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        if (captureFire) begin
          state_d = CAPTURED;
        end else if (rearm) begin
          state_d = ARMED;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // Capture FSM: outputs
  always_comb begin
    firstValid = 1'b0;
    case (state_q)
      ARMED:    firstValid = 1'b0;
      CAPTURED: firstValid = 1'b1;
      default:  firstValid = 1'b0;
    endcase
  end

  // Next values for the latches, mask and captured position. When a clear
  // and a new hit coincide, the hit is OR-ed in after the clear. This way
  // the new hit survives.
  always_comb begin
    cx_d     = (wrCx ? 15'd0 : cx_q) | hit;

    mask_d   = mask_q;
    if (wrMaskLo) begin
      mask_d[7:0] = data_in;
    end
    if (wrMaskHi) begin
      mask_d[14:8] = data_in[6:0];
    end

    firstH_d = firstH_q;
    firstV_d = firstV_q;
    if (captureFire) begin
      firstH_d = hpos;
      firstV_d = vpos;
    end
  end

`ifdef COLLISION_IRQ_EN
  logic irqPending_q, irqPending_d;

  // The pending flag sets on any capture. Software clears it through 0x8
  // bit1. If both happen in one cycle, the set wins so no capture is lost.
  always_comb begin
    irqPending_d = irqPending_q;
    if (wrCtrl && data_in[1]) begin
      irqPending_d = 1'b0;
    end
    if (captureFire) begin
      irqPending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqPending_q <= 1'b0;
    end else begin
      irqPending_q <= irqPending_d;
    end
  end

  assign irqPending = irqPending_q;
  assign irq        = irqPending_q;
`else
  assign irqPending = 1'b0;
  assign irq        = 1'b0;
`endif

  // Read mux. Position high bytes carry only bits [9:8], shifted down.
  always_comb begin
    readData = 8'h00;
    case (address)
      4'h0:    readData = cx_q[7:0];
      4'h1:    readData = {1'b0, cx_q[14:8]};
      4'h2:    readData = mask_q[7:0];
      4'h3:    readData = {1'b0, mask_q[14:8]};
      4'h4:    readData = 8'(firstH_q);
      4'h5:    readData = 8'(firstH_q >> 8) & 8'h03;
      4'h6:    readData = 8'(firstV_q);
      4'h7:    readData = 8'(firstV_q >> 8) & 8'h03;
      4'h8:    readData = {6'b0, irqPending, firstValid};
      default: readData = 8'h00;
    endcase
  end

  // A read happens only when enable is high without write_enable. When both
  // strobes are high, the write goes ahead and data_out keeps its old value.
  always_comb begin
    dataOut_d = dataOut_q;
    if (enable && !write_enable) begin
      dataOut_d = readData;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_q      <= '0;
      mask_q    <= '0;
      firstH_q  <= '0;
      firstV_q  <= '0;
      dataOut_q <= '0;
    end else begin
      cx_q      <= cx_d;
      mask_q    <= mask_d;
      firstH_q  <= firstH_d;
      firstV_q  <= firstV_d;
      dataOut_q <= dataOut_d;
    end
  end

  assign data_out = dataOut_q;

endmodule

// File: tb/tb_collision_detect.sv
// ---------------------------------------------------------------------------
// tb_collision_detect
//
// Self-checking bench for collision_detect. Directed scenarios compare
// against constant expected values. A randomized run is compared cycle by
// cycle against a behavioural model of the collision rules. The model
// enumerates object pairs with a nested loop over the six objects.
// ---------------------------------------------------------------------------
module tb_collision_detect;

`ifdef COLLISION_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pixel_strobe = 1'b0;
  logic       in_image = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic [5:0] obj_values = '0;
  logic [3:0] address = '0;
  logic [7:0] data_in = '0;
  logic       write_enable = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_out;
  logic       irq;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [14:0] mCx, mMask;
  logic        mValid, mIrq;
  logic [9:0]  mH, mV;
  logic [7:0]  mDataOut;

  collision_detect #(.POS_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .pixel_strobe(pixel_strobe), .in_image(in_image),
    .frame_start(frame_start), .hpos(hpos), .vpos(vpos), .obj_values(obj_values),
    .address(address), .data_in(data_in), .write_enable(write_enable),
    .enable(enable), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Clears the model to its reset values.
  task automatic modelReset();
    mCx = '0; mMask = '0; mValid = 1'b0; mIrq = 1'b0;
    mH = '0; mV = '0; mDataOut = '0;
  endtask

  // Register view of the model.
  function automatic logic [7:0] modelRead(input logic [3:0] a);
    case (a)
      4'h0: return mCx[7:0];
      4'h1: return {1'b0, mCx[14:8]};
      4'h2: return mMask[7:0];
      4'h3: return {1'b0, mMask[14:8]};
      4'h4: return mH[7:0];
      4'h5: return {6'b0, mH[9:8]};
      4'h6: return mV[7:0];
      4'h7: return {6'b0, mV[9:8]};
      4'h8: return {6'b0, (IRQ_ON & mIrq), mValid};
      default: return 8'h00;
    endcase
  endfunction

  // Applies one clock's worth of collision rules to the model.
  task automatic modelStep(input logic [5:0] obj, input logic ps, ii, fs,
                           input logic [9:0] h, v, input logic we, en,
                           input logic [3:0] a, input logic [7:0] d);
    logic [14:0] hits;
    int n;
    logic rearm, armed, cap;
    hits = '0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      for (int j = i + 1; j < 6; j++) begin
        hits[n] = ps && ii && obj[i] && obj[j];
        n++;
      end
    end
    if (en && !we) mDataOut = modelRead(a);
    rearm = fs || (we && a == 4'h8 && d[0]);
    armed = !mValid || rearm;
    cap   = armed && ((hits & ~mMask) != 0);
    if (cap) begin
      mValid = 1'b1; mH = h; mV = v;
    end else if (rearm) begin
      mValid = 1'b0;
    end
    if (we && a == 4'h8 && d[1]) mIrq = 1'b0;
    if (cap) mIrq = 1'b1;
    if (we && (a == 4'h0 || a == 4'h1)) mCx = '0;
    mCx = mCx | hits;
    if (we && a == 4'h2) mMask[7:0] = d;
    if (we && a == 4'h3) mMask[14:8] = d[6:0];
  endtask

  // Drives one cycle of stimulus on the falling edge, lets the rising edge
  // happen, steps the model, then idles just after the edge for sampling.
  task automatic applyStimulus(input logic [5:0] obj, input logic ps, ii, fs,
                               input int h, v, input logic we, en,
                               input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    obj_values = obj; pixel_strobe = ps; in_image = ii; frame_start = fs;
    hpos = 10'(h); vpos = 10'(v); write_enable = we; enable = en;
    address = a; data_in = d;
    @(posedge clk);
    modelStep(obj, ps, ii, fs, 10'(h), 10'(v), we, en, a, d);
    #1;
    obj_values = '0; pixel_strobe = 0; in_image = 0; frame_start = 0;
    write_enable = 0; enable = 0;
  endtask

  task automatic hitCycle(input logic [5:0] obj, input int h, v);
    applyStimulus(obj, 1'b1, 1'b1, 1'b0, h, v, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [7:0] d);
    applyStimulus(6'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, a, d);
  endtask

  task automatic readReg(input logic [3:0] a, output logic [7:0] val);
    applyStimulus(6'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, a, 8'h00);
    val = data_out;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    logic [7:0] r;
    pulseReset();
    for (int a = 0; a <= 8; a++) begin
      readReg(4'(a), r);
      checks++;
      if (r !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_reg%0h got=%02h want=00", a, r);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_irq got=%b want=0", irq);
    end
  endtask

  task automatic test_basic_hit();
    logic [7:0] r;
    pulseReset();
    hitCycle(6'b000011, 100, 37);
    readReg(4'h0, r); checks++;
    if (r !== 8'h01) begin failures++; $display("[TB] FAIL basic_cx0 got=%02h want=01", r); end
    readReg(4'h4, r); checks++;
    if (r !== 8'h64) begin failures++; $display("[TB] FAIL basic_h0 got=%02h want=64", r); end
    readReg(4'h5, r); checks++;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL basic_h1 got=%02h want=00", r); end
    readReg(4'h6, r); checks++;
    if (r !== 8'h25) begin failures++; $display("[TB] FAIL basic_v0 got=%02h want=25", r); end
    readReg(4'h8, r); checks++;
    if (r !== (IRQ_ON ? 8'h03 : 8'h01)) begin
      failures++; $display("[TB] FAIL basic_status got=%02h want=%02h", r, IRQ_ON ? 8'h03 : 8'h01);
    end
    checks++;
    if (irq !== IRQ_ON) begin failures++; $display("[TB] FAIL basic_irq got=%b want=%b", irq, IRQ_ON); end
  endtask

  task automatic test_qualifiers();
    logic [7:0] r;
    for (int k = 0; k < 2; k++) begin
      pulseReset();
      applyStimulus(6'b000011, k == 0, k == 1, 1'b0, 100, 37, 1'b0, 1'b0, 4'h0, 8'h00);
      readReg(4'h0, r); checks++;
      if (r !== 8'h00) begin failures++; $display("[TB] FAIL qual%0d_cx got=%02h want=00", k, r); end
      readReg(4'h8, r); checks++;
      if (r !== 8'h00) begin failures++; $display("[TB] FAIL qual%0d_status got=%02h want=00", k, r); end
    end
  endtask

  task automatic test_mask();
    logic [7:0] r;
    pulseReset();
    writeReg(4'h3, 8'h40);
    hitCycle(6'b110000, 600, 10);
    readReg(4'h1, r); checks++;
    if (r !== 8'h40) begin failures++; $display("[TB] FAIL mask_cx1 got=%02h want=40", r); end
    readReg(4'h8, r); checks++;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL mask_status got=%02h want=00", r); end
    hitCycle(6'b000101, 601, 11);
    readReg(4'h0, r); checks++;
    if (r !== 8'h02) begin failures++; $display("[TB] FAIL mask_cx0 got=%02h want=02", r); end
    readReg(4'h5, r); checks++;
    if (r !== 8'h02) begin failures++; $display("[TB] FAIL mask_h1 got=%02h want=02", r); end
    readReg(4'h4, r); checks++;
    if (r !== 8'h59) begin failures++; $display("[TB] FAIL mask_h0 got=%02h want=59", r); end
  endtask

  task automatic test_clear_vs_hit();
    logic [7:0] r;
    pulseReset();
    hitCycle(6'b111111, 20, 30);
    readReg(4'h1, r); checks++;
    if (r !== 8'h7F) begin failures++; $display("[TB] FAIL allhit_cx1 got=%02h want=7F", r); end
    applyStimulus(6'b001100, 1'b1, 1'b1, 1'b0, 21, 30, 1'b1, 1'b0, 4'h0, 8'hA5);
    readReg(4'h0, r); checks++;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL clrhit_cx0 got=%02h want=00", r); end
    readReg(4'h1, r); checks++;
    if (r !== 8'h02) begin failures++; $display("[TB] FAIL clrhit_cx1 got=%02h want=02", r); end
  endtask

  // Relies on the capture left behind by test_clear_vs_hit.
  task automatic test_rearm();
    logic [7:0] r;
    applyStimulus(6'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    readReg(4'h8, r); checks++;
    if (r !== (IRQ_ON ? 8'h02 : 8'h00)) begin
      failures++; $display("[TB] FAIL rearm_status got=%02h want=%02h", r, IRQ_ON ? 8'h02 : 8'h00);
    end
    hitCycle(6'b000011, 5, 500);
    hitCycle(6'b000011, 6, 501);
    readReg(4'h7, r); checks++;
    if (r !== 8'h01) begin failures++; $display("[TB] FAIL rearm_v1 got=%02h want=01", r); end
    readReg(4'h6, r); checks++;
    if (r !== 8'hF4) begin failures++; $display("[TB] FAIL rearm_v0 got=%02h want=F4", r); end
    readReg(4'h4, r); checks++;
    if (r !== 8'h05) begin failures++; $display("[TB] FAIL rearm_h0 got=%02h want=05", r); end
    writeReg(4'h8, 8'h02);
    readReg(4'h8, r); checks++;
    if (r !== 8'h01) begin failures++; $display("[TB] FAIL irqclr_status got=%02h want=01", r); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irqclr_irq got=%b want=0", irq); end
  endtask

  task automatic test_random();
    logic [5:0] obj;
    logic ps, ii, fs, we, en;
    logic [3:0] a;
    logic [7:0] d;
    pulseReset();
    for (int c = 0; c < 3000; c++) begin
      obj = 6'($urandom);
      ps  = ($urandom_range(0, 3) != 0);
      ii  = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 40) == 0);
      we  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 1) == 1);
      a   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
      d   = 8'($urandom);
      applyStimulus(obj, ps, ii, fs, $urandom_range(0, 1023), $urandom_range(0, 1023),
                    we, en, a, d);
      checks++;
      if (data_out !== mDataOut) begin
        failures++;
        $display("[TB] FAIL rand_data cycle=%0d got=%02h want=%02h", c, data_out, mDataOut);
      end
      checks++;
      if (irq !== (IRQ_ON & mIrq)) begin
        failures++;
        $display("[TB] FAIL rand_irq cycle=%0d got=%b want=%b", c, irq, IRQ_ON & mIrq);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] r;
    pulseReset();
    hitCycle(6'b000011, 300, 200);
    readReg(4'h0, r); checks++;
    if (r !== 8'h01) begin failures++; $display("[TB] FAIL areset_pre got=%02h want=01", r); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL areset_data got=%02h want=00", data_out); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL areset_irq got=%b want=0", irq); end
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    readReg(4'h0, r); checks++;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL areset_cx got=%02h want=00", r); end
    readReg(4'h8, r); checks++;
    if (r !== 8'h00) begin failures++; $display("[TB] FAIL areset_status got=%02h want=00", r); end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_basic_hit();
    test_qualifiers();
    test_mask();
    test_clear_vs_hit();
    test_rearm();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
